icache: RTL and testbench
=========================

# icache

Direct-mapped, one-word-per-line instruction cache between the IF stage and the byte-wide memory arbiter. It serves IF's combinational fetch lookups and raises a miss while the line is absent. On a miss it fetches the 32-bit word byte by byte over the memory port, installs it, then presents it as a hit. IF holds its address stable for the whole miss.

## Interface
- INDEX_BITS, 7: line index width; 2^INDEX_BITS lines; tag width = 30 − INDEX_BITS.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- re_IF_i  in  1  fetch request from IF.
- addr_IF_i  in  32  fetch address; bits [1:0] ignored.
- data_IF_o  out  32  instruction word; combinational.
- miss_IF_o  out  1  word not yet available; combinational.
- mem_req_o  out  1  byte read request to arbiter.
- mem_addr_o  out  32  byte address of current request.
- mem_data_i  in  8  returned byte, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle pulse; byte for current mem_addr_o delivered.
- flush_i  in  1  invalidate all lines (only with ICACHE_FLUSH_EN).

## Operation
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
- hit = valid[index] && tag_arr[index] == tag && state == IDLE.
- data_IF_o = hit ? data_arr[index] : 0.
- miss_IF_o = re_IF_i && !hit. It is 0 whenever re_IF_i = 0, even mid-fill.
- States:
  - IDLE: if re_IF_i && !hit, latch {tag, index} into fill_addr, clear cnt, go to FETCH.
  - FETCH: mem_req_o = 1, mem_addr_o = {fill_addr, 2'b00} + cnt.
    - On mem_ack_i with cnt < 3: store mem_data_i into buf byte cnt, then cnt++.
    - On mem_ack_i with cnt == 3: write {mem_data_i, buf[23:0]} to data_arr, write the tag, set valid, go to IDLE.
- Byte order is little-endian: byte 0 → bits [7:0].
- A fill always completes for the latched address, even if addr_IF_i or re_IF_i changes. The new address is looked up in IDLE afterwards.
- mem_req_o stays high continuously through FETCH and drops in IDLE.
- mem_ack_i outside FETCH is ignored.

## Timing
- Hit: zero latency; data is valid in the same cycle as the address.
- Miss with immediate acks:
  - Cycle 0: miss detected.
  - Cycles 1–4: requests and acks.
  - Cycle 5: hit, miss_IF_o = 0.
  - Minimum penalty is 5 cycles; each ack gap adds one cycle.
- Reset values:
  - state IDLE, cnt 0, buf 0, fill_addr 0, all valid bits 0.
  - mem_req_o 0, mem_addr_o 0.
  - data_IF_o 0; miss_IF_o follows re_IF_i.
- rst mid-fill: asynchronous return to IDLE, mem_req_o drops immediately, and the partial line is discarded.
- Conflict: a fill overwrites the resident line at the same index.

## Configuration
- ICACHE_FLUSH_EN defined:
  - The flush_i port exists.
  - flush_i = 1 at a posedge clears all valid bits.
  - If a fill is in progress, the fill is aborted: state goes to IDLE, mem_req_o drops next cycle, and no line is written. This applies even if it is the cnt == 3 ack edge.
  - If IF is still requesting, the next IDLE cycle misses again and restarts the fill from byte 0.
- Undefined: no flush_i port; lines are invalidated only by rst.

## Structure
- Shared package/header:
  - State encodings ICACHE_IDLE and ICACHE_FETCH.
  - Default INDEX_BITS.
  - Use the existing Enable/Disable/ZeroWord macros.
- Sub-module icache_array: valid/tag/data storage with one combinational read port and one synchronous write port. The valid vector is reset asynchronously and cleared by flush.
- icache top level: FSM, byte counter, assembly buffer, and hit logic.

## Test plan
1. Reset, then re=1, addr 0x0; memory returns 0x13, 0x00, 0x00, 0x00 with same-cycle acks.
   - miss_IF_o = 1 in cycles 0–4.
   - mem_addr_o steps 0x0 → 0x3.
   - Cycle 5: data_IF_o = 0x00000013, miss_IF_o = 0.
2. After test 1, access 0x0 and 0x4.
   - 0x0 hits with no mem_req_o.
   - 0x4 misses and fetches 0x4–0x7.
3. INDEX_BITS = 7: fill 0x0, then fill 0x200 (same index 0).
   - A subsequent access to 0x0 misses again and refetches.
4. Acks every third cycle.
   - miss_IF_o stays high until the cycle after the fourth ack.
   - mem_addr_o advances only on acks.
   - The assembled word is correct.
5. rst asserted after two acks.
   - mem_req_o = 0 immediately.
   - A re-access to 0x0 misses and fetches starting at byte 0x0.
6. With ICACHE_FLUSH_EN: after filling 0x0, pulse flush_i, then access 0x0.
   - The access misses.
   - A flush during a fill aborts it, and no valid bit is set for the aborted line.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM state encodings, default
// geometry and the common Enable/Disable/ZeroWord constants.
// Optional feature macro: ICACHE_FLUSH_EN (adds flush_i line invalidation).

`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif

package icache_pkg;

    // Default number of index bits (2^7 = 128 one-word lines).
    localparam int unsigned ICACHE_INDEX_BITS = 7;

    typedef enum logic {
        ICACHE_IDLE  = 1'b0,
        ICACHE_FETCH = 1'b1
    } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache: one combinational read
// port, one synchronous write port. Valid bits reset asynchronously and are
// cleared by flush; tag/data storage is not reset since valid gates it.
// Optional feature macro: ICACHE_FLUSH_EN (drives flush from the top level).

module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [29-INDEX_BITS:0] rd_tag,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [29-INDEX_BITS:0] wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int unsigned Lines = 1 << INDEX_BITS;

    logic [Lines-1:0]          valid_q;
    logic [29-INDEX_BITS:0]    tag_q  [Lines];
    logic [31:0]               data_q [Lines];

    // Valid vector: async reset, flush wins over a same-edge install.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= `Enable;
        end
    end

    // Tag and data storage written on line install.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Serves combinational
// fetch lookups from IF and fills missing lines byte by byte (little-endian)
// over the byte-wide memory port.
// Optional feature macro: ICACHE_FLUSH_EN (adds flush_i, which invalidates all
// lines and aborts any fill in progress).

module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        re_IF_i,
    input  logic [31:0] addr_IF_i,
    output logic [31:0] data_IF_o,
    output logic        miss_IF_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [7:0]  mem_data_i,
`ifdef ICACHE_FLUSH_EN
    input  logic        flush_i,
`endif
    input  logic        mem_ack_i
);

    localparam int unsigned TagBits = 30 - INDEX_BITS;

    logic [INDEX_BITS-1:0] index;
    logic [TagBits-1:0]    tag;
    logic                  rd_valid;
    logic [TagBits-1:0]    rd_tag;
    logic [31:0]           rd_data;
    logic                  hit;
    logic                  flush;
    logic                  wr_en;
    logic                  unused_addr_lsbs;

    icache_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   buf_q, buf_d;     // bytes 0..2; byte 3 goes straight to the array
    logic [29:0]   fill_q, fill_d;   // {tag, index} of the line being filled

    assign index            = addr_IF_i[INDEX_BITS+1:2];
    assign tag              = addr_IF_i[31:INDEX_BITS+2];
    assign unused_addr_lsbs = ^addr_IF_i[1:0];

`ifdef ICACHE_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = `Disable;
`endif

    icache_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .rd_index (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_index (fill_q[INDEX_BITS-1:0]),
        .wr_tag   (fill_q[29:INDEX_BITS]),
        .wr_data  ({mem_data_i, buf_q})
    );

    // Hit only while idle so a word is never presented mid-fill.
    always_comb begin
        hit       = rd_valid && (rd_tag == tag) && (state_q == ICACHE_IDLE);
        data_IF_o = hit ? rd_data : `ZeroWord;
        miss_IF_o = re_IF_i && !hit;
    end

    // Memory port is a pure function of the fill state so rst drops it at once.
    always_comb begin
        mem_req_o  = (state_q == ICACHE_FETCH);
        mem_addr_o = mem_req_o ? ({fill_q, 2'b00} + {30'd0, cnt_q}) : `ZeroWord;
    end

    // Next-state logic: start fills on IDLE misses, assemble bytes in FETCH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        fill_d  = fill_q;
        wr_en   = `Disable;
        unique case (state_q)
            ICACHE_IDLE: begin
                if (re_IF_i && !hit) begin
                    fill_d  = {tag, index};
                    cnt_d   = 2'd0;
                    state_d = ICACHE_FETCH;
                end
            end
            ICACHE_FETCH: begin
                if (mem_ack_i) begin
                    case (cnt_q)
                        2'd0: buf_d[7:0]   = mem_data_i;
                        2'd1: buf_d[15:8]  = mem_data_i;
                        2'd2: buf_d[23:16] = mem_data_i;
                        default: begin
                            wr_en   = `Enable;
                            state_d = ICACHE_IDLE;
                        end
                    endcase
                    if (cnt_q != 2'd3) begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
        // Flush aborts any fill, including one completing on this edge.
        if (flush) begin
            wr_en   = `Disable;
            state_d = ICACHE_IDLE;
        end
    end

    // State, counter, buffer and fill address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ICACHE_IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a negedge memory responder with configurable
// ack spacing, expected words queued per fetch and compared when miss drops.
`timescale 1ns/1ps

module tb_icache;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] data_o;
    logic        miss;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data = 8'h0;
    logic        mem_ack = 1'b0;
`ifdef ICACHE_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int ack_gap = 0;
    int wait_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] addr_log[$];

    always #5 clk = ~clk;

    icache #(
        .INDEX_BITS(7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .re_IF_i    (re),
        .addr_IF_i  (addr),
        .data_IF_o  (data_o),
        .miss_IF_o  (miss),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_data_i (mem_data),
`ifdef ICACHE_FLUSH_EN
        .flush_i    (flush),
`endif
        .mem_ack_i  (mem_ack)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        if (a[31:2] == 30'd0) return (a[1:0] == 2'd0) ? 8'h13 : 8'h00;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {mem_byte(a + 3), mem_byte(a + 2), mem_byte(a + 1), mem_byte(a)};
    endfunction

    // Memory model: acks every (ack_gap+1)-th requested cycle, logs acked addresses.
    always @(negedge clk) begin
        if (rst || !mem_req) begin
            mem_ack = 1'b0;
            wait_cnt = 0;
        end else if (wait_cnt >= ack_gap) begin
            mem_ack = 1'b1;
            mem_data = mem_byte(mem_addr);
            addr_log.push_back(mem_addr);
            wait_cnt = 0;
        end else begin
            mem_ack = 1'b0;
            wait_cnt++;
        end
    end

    // Drive one fetch and count cycles with miss high until the word appears.
    task automatic do_fetch(input logic [31:0] a, output int cycles,
                            output logic [31:0] data, output bit done);
        addr_log.delete();
        cycles = 0;
        done = 1'b0;
        data = 32'h0;
        @(negedge clk);
        re = 1'b1;
        addr = a;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (!miss) begin
                data = data_o;
                done = 1'b1;
                break;
            end
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        re = 1'b0;
        #2;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", mem_req); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", mem_addr); end
        total++; if (data_o !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", data_o); end
        total++; if (miss !== 1'b0) begin bad++; $display("FAIL rst_miss_re0 got=%b want=0", miss); end
        re = 1'b1;
        #1;
        total++; if (miss !== 1'b1) begin bad++; $display("FAIL rst_miss_re1 got=%b want=1", miss); end
        re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_fill();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw;
        exp_q.push_back(word_of(32'h0));
        do_fetch(32'h0, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL fill0_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL fill0_penalty got=%0d want=5", cyc); end
        total++; if (addr_log.size() != 4) begin bad++; $display("FAIL fill0_acks got=%0d want=4", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            total++;
            if (addr_log[i] !== 32'(i)) begin
                bad++; $display("FAIL fill0_addr%0d got=%h want=%h", i, addr_log[i], 32'(i));
            end
        end
    endtask

    task automatic test_hit();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw;
        exp_q.push_back(word_of(32'h0));
        do_fetch(32'h0, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL hit0_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 0) begin bad++; $display("FAIL hit0_latency got=%0d want=0", cyc); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hit0_req got=%b want=0", mem_req); end
        exp_q.push_back(word_of(32'h4));
        do_fetch(32'h4, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL fill4_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL fill4_penalty got=%0d want=5", cyc); end
        total++;
        if (addr_log.size() != 4 || addr_log[0] !== 32'h4 || addr_log[3] !== 32'h7) begin
            bad++; $display("FAIL fill4_addrs got_n=%0d want_n=4 first/last want=4/7", addr_log.size());
        end
    endtask

    task automatic test_conflict();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw;
        exp_q.push_back(word_of(32'h200));
        do_fetch(32'h200, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL c200_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL c200_penalty got=%0d want=5", cyc); end
        exp_q.push_back(word_of(32'h0));
        do_fetch(32'h0, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL c0_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL c0_refetch got=%0d want=5", cyc); end
    endtask

    task automatic test_ack_gap();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw;
        ack_gap = 2;
        exp_q.push_back(word_of(32'h88));
        do_fetch(32'h88, cyc, dat, ok);
        expw = exp_q.pop_front();
        ack_gap = 0;
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL gap_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 13) begin bad++; $display("FAIL gap_penalty got=%0d want=13", cyc); end
        total++; if (addr_log.size() != 4) begin bad++; $display("FAIL gap_acks got=%0d want=4", addr_log.size()); end
        for (int i = 0; i < addr_log.size(); i++) begin
            total++;
            if (addr_log[i] !== 32'h88 + 32'(i)) begin
                bad++; $display("FAIL gap_addr%0d got=%h want=%h", i, addr_log[i], 32'h88 + 32'(i));
            end
        end
    endtask

    task automatic test_rst_midfill();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw;
        re = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        addr_log.delete();
        @(negedge clk);
        re = 1'b1;
        addr = 32'h0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            if (addr_log.size() >= 2) break;
        end
        total++; if (addr_log.size() != 2) begin bad++; $display("FAIL rmf_acks got=%0d want=2", addr_log.size()); end
        #1 rst = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmf_req got=%b want=0", mem_req); end
        total++; if (miss !== 1'b1) begin bad++; $display("FAIL rmf_miss got=%b want=1", miss); end
        re = 1'b0;
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(word_of(32'h0));
        do_fetch(32'h0, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL rmf_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL rmf_penalty got=%0d want=5", cyc); end
        total++;
        if (addr_log.size() == 0 || addr_log[0] !== 32'h0) begin
            bad++; $display("FAIL rmf_first_addr got_n=%0d want first=0", addr_log.size());
        end
    endtask

`ifdef ICACHE_FLUSH_EN
    task automatic test_flush();
        int cyc; logic [31:0] dat; bit ok; logic [31:0] expw; logic [31:0] a;
        re = 1'b0;
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        exp_q.push_back(word_of(32'h0));
        do_fetch(32'h0, cyc, dat, ok);
        expw = exp_q.pop_front();
        total++; if (!ok || dat !== expw) begin bad++; $display("FAIL fl0_data got=%h want=%h", dat, expw); end
        total++; if (cyc != 5) begin bad++; $display("FAIL fl0_penalty got=%0d want=5", cyc); end
        // Abort after 2 acks, then on the edge carrying the final ack.
        for (int n = 2; n <= 4; n += 2) begin
            a = 32'h40 + 32'(n * 16);
            re = 1'b0;
            addr_log.delete();
            @(negedge clk);
            re = 1'b1;
            addr = a;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                #1;
                if (addr_log.size() >= n) break;
            end
            re = 1'b0;
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            #1;
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL flab%0d_req got=%b want=0", n, mem_req); end
            exp_q.push_back(word_of(a));
            do_fetch(a, cyc, dat, ok);
            expw = exp_q.pop_front();
            total++; if (!ok || dat !== expw) begin bad++; $display("FAIL flab%0d_data got=%h want=%h", n, dat, expw); end
            total++; if (cyc != 5) begin bad++; $display("FAIL flab%0d_penalty got=%0d want=5", n, cyc); end
            total++;
            if (addr_log.size() == 0 || addr_log[0] !== a) begin
                bad++; $display("FAIL flab%0d_first_addr got_n=%0d want first=%h", n, addr_log.size(), a);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fill();
        test_hit();
        test_conflict();
        test_ack_gap();
        test_rst_midfill();
`ifdef ICACHE_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
